rx_audio_frame_rd: RTL
======================

# rx_audio_frame_rd

CPU-clock-domain reader for the shared rx audio sample buffer. Drains one complete frame per buffer-written event: interleaved I/Q/third words for every sample of every channel, then 3 tick words, then 1 buffer-counter word. Streams the IQ words out under valid/ready and captures ticks and counter into registers. Tracks frames pending, detects dropped frames, and sits between the buffer read port (get_rx_samp_C / doutb) and the SPI transfer logic.

## Interface
Parameters:
- RXBUF_FRAMES, 8, maximum frames the buffer holds; frames_avail saturates here.
- CNT_W, 4, width of frames_avail; must hold RXBUF_FRAMES.

Ports:
- cpu_clk  in  1  sole clock; one clock; reset is synchronous and active-low.
- reset_n  in  1  synchronous, active-low reset.
- nrx_samps  in  16  samples per channel per frame; sampled at frame start.
- nrx_chans  in  4  interleaved channels, 0..8; sampled at frame start.
- run  in  1  start new frames while high; a frame in progress always completes.
- frame_inc  in  1  one-cycle pulse per frame completed by the writer (synced srq).
- buf_rd  out  1  buffer read strobe; advances buffer raddr.
- buf_dout  in  16  buffer data, valid the cycle after buf_rd.
- m_data  out  16  IQ word stream.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts when m_valid and m_ready are both high.
- m_last  out  1  high with the final IQ word of a frame.
- ticks  out  48  last captured timestamp.
- ticks_valid  out  1  one-cycle pulse when ticks updates.
- buf_ctr  out  16  last captured buffer counter.
- seq_err  out  1  sticky counter-discontinuity flag.
- overflow  out  1  sticky frames_avail saturation flag.
- clr_err  in  1  clears seq_err and overflow.
- frames_avail  out  CNT_W  frames written but not yet fully read.

## Operation
- Reset values: all outputs 0; state IDLE; expected counter 0; skid FIFO empty.
- Frame length: nwords = nrx_samps × nrx_chans × 3, computed as 21-bit unsigned and latched on IDLE→IQ.
- States:
  - IDLE → IQ when run && frames_avail≠0. Goes directly to TS when nwords=0.
  - IQ: issue buf_rd while words remain. Every returned word goes through a 2-entry FIFO to m_data. Leave for TS after the last IQ read has been issued.
  - TS: three reads, captured LSW first into ticks[15:0], ticks[31:16], ticks[47:32]. ticks_valid pulses on the cycle after the third word lands.
  - CTR: one read, captured into buf_ctr. Then DONE.
  - DONE: frames_avail decrements. Sequence check runs. Returns to IDLE.
- Flow control:
  - In IQ, buf_rd=1 iff FIFO occupancy + in-flight reads − pop_this_cycle < 2.
  - Never more than 2 words outstanding. No data is lost under any m_ready pattern.
  - TS and CTR reads do not start until the FIFO has drained, so stream order stays intact.
- m_last is asserted on word nwords−1 only. It is never asserted when nwords=0.
- frames_avail:
  - +1 on frame_inc, −1 in DONE; unchanged when both happen in the same cycle.
  - Saturates at RXBUF_FRAMES; frame_inc while saturated sets overflow.
- clr_err clears the sticky flags in the cycle it is seen. If a set event occurs in the same cycle, set wins.
- Reset mid-frame: state machine, FIFO and counters return to reset values immediately. The buffer's own pointers must be reset with the same event.

## Timing
- frame_inc in cycle N → frames_avail=1 in N+1 → first buf_rd in N+2 → data in FIFO at N+3 → m_valid no earlier than N+4.
- Sustains one IQ word per cycle with m_ready held high.
- Frame overhead: 4 reads plus FIFO drain plus 2 cycles (IDLE, DONE).
- m_data, m_valid and m_last are registered. Once m_valid is high, they stay stable until accepted.

## Configuration
- RX_FRAME_SEQ_CHECK_EN defined:
  - In DONE, if buf_ctr ≠ expected, set seq_err.
  - Expected then becomes buf_ctr+1 (16-bit wrap 0xFFFF→0x0000 is not an error).
- Undefined: seq_err is tied 0 and no expected counter is built. buf_ctr is still captured.

## Test plan
- nrx_samps=4, nrx_chans=2, m_ready=1, one frame_inc → 24 IQ words in order; m_last on the 24th; ticks=0x0000_1234_5678 from words 0x5678,0x1234,0x0000; buf_ctr=0; frames_avail 1→0.
- Same frame with m_ready toggling 1-of-3 cycles → identical word sequence, no drops or duplicates; at most 2 reads outstanding.
- nrx_chans=0, one frame_inc → no m_valid; exactly 4 buf_rd; ticks_valid pulses once.
- Ten frame_inc with run=0 → frames_avail=8, overflow=1; clr_err → overflow=0.
- With RX_FRAME_SEQ_CHECK_EN, frame counters 0,1,3 → seq_err set after the third frame; counter 4 next → no new error.
- reset_n low mid-IQ for 1 cycle → all outputs 0, state IDLE; next frame_inc produces a complete frame.

Source files
------------

// File: rtl/rx_audio_frame_rd_if.sv
// Word stream from the rx frame reader to the SPI transfer logic.
// The master drives data/valid/last and the slave answers with ready.
interface rx_audio_frame_rd_if;
    logic [15:0] data;
    logic        valid;
    logic        ready;
    logic        last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/rx_audio_frame_rd.sv
// Drains one rx sample-buffer frame per frame_inc: IQ words to the stream, then 3 tick words and 1 counter word.
// Optional macro RX_FRAME_SEQ_CHECK_EN builds the buffer-counter continuity check driving seq_err.
module rx_audio_frame_rd #(
    parameter int RXBUF_FRAMES = 8,
    parameter int CNT_W        = 4
) (
    input  logic                cpu_clk,
    input  logic                reset_n,
    input  logic [15:0]         nrx_samps,
    input  logic [3:0]          nrx_chans,
    input  logic                run,
    input  logic                frame_inc,
    output logic                buf_rd,
    input  logic [15:0]         buf_dout,
    rx_audio_frame_rd_if.master m,
    output logic [47:0]         ticks,
    output logic                ticks_valid,
    output logic [15:0]         buf_ctr,
    output logic                seq_err,
    output logic                overflow,
    input  logic                clr_err,
    output logic [CNT_W-1:0]    frames_avail
);
    typedef enum logic [2:0] {IDLE, IQ, TS, CTR, DONE} state_t;
    typedef enum logic [2:0] {TAG_NONE, TAG_IQ, TAG_IQL, TAG_T0, TAG_T1, TAG_T2, TAG_CTR} tag_t;

    state_t           state_q, state_d;
    tag_t             rd_tag_q, rd_tag_d;
    logic [20:0]      nwords_q, nwords_d, rd_cnt_q, rd_cnt_d, nwords_calc;
    logic [1:0]       ts_cnt_q, ts_cnt_d;
    logic [15:0]      out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic             skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
    logic [47:0]      ticks_q, ticks_d;
    logic             ticks_valid_q, ticks_valid_d;
    logic [15:0]      buf_ctr_q, buf_ctr_d;
    logic             overflow_q, overflow_d, ovf_set;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic             pop, push, push_last, iq_pend;
    logic [2:0]       credit;

    assign nwords_calc = 21'(nrx_samps) * 21'(nrx_chans) * 21'd3;

    // Each read is tagged so the word returning next cycle is routed without extra counters.
    assign pop       = out_valid_q && m.ready;
    assign push      = (rd_tag_q == TAG_IQ) || (rd_tag_q == TAG_IQL);
    assign push_last = (rd_tag_q == TAG_IQL);
    assign iq_pend   = push;
    assign credit    = {2'b00, out_valid_q} + {2'b00, skid_valid_q} + {2'b00, iq_pend};

    always_comb begin
        state_d       = state_q;
        rd_tag_d      = TAG_NONE;
        nwords_d      = nwords_q;
        rd_cnt_d      = rd_cnt_q;
        ts_cnt_d      = ts_cnt_q;
        buf_rd        = 1'b0;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        skid_data_d   = skid_data_q;
        skid_valid_d  = skid_valid_q;
        skid_last_d   = skid_last_q;
        ticks_d       = ticks_q;
        ticks_valid_d = 1'b0;
        buf_ctr_d     = buf_ctr_q;
        frames_d      = frames_q;
        ovf_set       = 1'b0;

        case (state_q)
            IDLE: begin
                if (run && (frames_q != '0)) begin
                    nwords_d = nwords_calc;
                    rd_cnt_d = '0;
                    ts_cnt_d = '0;
                    state_d  = (nwords_calc == '0) ? TS : IQ;
                end
            end
            IQ: begin
                if (credit < (3'd2 + {2'b00, pop})) begin
                    buf_rd   = 1'b1;
                    rd_cnt_d = rd_cnt_q + 21'd1;
                    if (rd_cnt_q == nwords_q - 21'd1) begin
                        rd_tag_d = TAG_IQL;
                        state_d  = TS;
                    end else begin
                        rd_tag_d = TAG_IQ;
                    end
                end
            end
            TS: begin
                // Tick reads wait for the stream to empty so they never overtake IQ words.
                if (!out_valid_q && !skid_valid_q && !iq_pend) begin
                    buf_rd   = 1'b1;
                    ts_cnt_d = ts_cnt_q + 2'd1;
                    case (ts_cnt_q)
                        2'd0:    rd_tag_d = TAG_T0;
                        2'd1:    rd_tag_d = TAG_T1;
                        default: begin
                            rd_tag_d = TAG_T2;
                            state_d  = CTR;
                        end
                    endcase
                end
            end
            CTR: begin
                buf_rd   = 1'b1;
                rd_tag_d = TAG_CTR;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (rd_tag_q)
            TAG_T0:  ticks_d[15:0]  = buf_dout;
            TAG_T1:  ticks_d[31:16] = buf_dout;
            TAG_T2: begin
                ticks_d[47:32] = buf_dout;
                ticks_valid_d  = 1'b1;
            end
            TAG_CTR: buf_ctr_d = buf_dout;
            default: ;
        endcase

        // Output register is the FIFO head; the skid entry catches the word in flight during a stall.
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                out_last_d   = skid_last_q;
                skid_valid_d = push;
                skid_data_d  = buf_dout;
                skid_last_d  = push_last;
            end else begin
                out_valid_d = push;
                out_data_d  = push ? buf_dout : out_data_q;
                out_last_d  = push && push_last;
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = buf_dout;
            skid_last_d  = push_last;
        end

        if (frame_inc && (state_q != DONE)) begin
            if (frames_q == CNT_W'(RXBUF_FRAMES)) begin
                ovf_set = 1'b1;
            end else begin
                frames_d = frames_q + CNT_W'(1);
            end
        end else if (!frame_inc && (state_q == DONE)) begin
            frames_d = frames_q - CNT_W'(1);
        end
        overflow_d = ovf_set | (overflow_q & ~clr_err);
    end

    always_ff @(posedge cpu_clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rd_tag_q      <= TAG_NONE;
            nwords_q      <= '0;
            rd_cnt_q      <= '0;
            ts_cnt_q      <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            skid_data_q   <= '0;
            skid_valid_q  <= 1'b0;
            skid_last_q   <= 1'b0;
            ticks_q       <= '0;
            ticks_valid_q <= 1'b0;
            buf_ctr_q     <= '0;
            overflow_q    <= 1'b0;
            frames_q      <= '0;
        end else begin
            state_q       <= state_d;
            rd_tag_q      <= rd_tag_d;
            nwords_q      <= nwords_d;
            rd_cnt_q      <= rd_cnt_d;
            ts_cnt_q      <= ts_cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            skid_data_q   <= skid_data_d;
            skid_valid_q  <= skid_valid_d;
            skid_last_q   <= skid_last_d;
            ticks_q       <= ticks_d;
            ticks_valid_q <= ticks_valid_d;
            buf_ctr_q     <= buf_ctr_d;
            overflow_q    <= overflow_d;
            frames_q      <= frames_d;
        end
    end

`ifdef RX_FRAME_SEQ_CHECK_EN
    logic [15:0] exp_ctr_q, exp_ctr_d;
    logic        seq_err_q, seq_err_d, seq_set;

    // In DONE the counter word is on buf_dout, landing in buf_ctr at the same edge.
    always_comb begin
        exp_ctr_d = exp_ctr_q;
        seq_set   = 1'b0;
        if (state_q == DONE) begin
            seq_set   = (buf_dout != exp_ctr_q);
            exp_ctr_d = buf_dout + 16'd1;
        end
        seq_err_d = seq_set | (seq_err_q & ~clr_err);
    end

    always_ff @(posedge cpu_clk) begin
        if (!reset_n) begin
            exp_ctr_q <= '0;
            seq_err_q <= 1'b0;
        end else begin
            exp_ctr_q <= exp_ctr_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

    assign m.data       = out_data_q;
    assign m.valid      = out_valid_q;
    assign m.last       = out_last_q;
    assign ticks        = ticks_q;
    assign ticks_valid  = ticks_valid_q;
    assign buf_ctr      = buf_ctr_q;
    assign overflow     = overflow_q;
    assign frames_avail = frames_q;
endmodule
